// File: rtl/ram_access_pkg.sv
// Shared types and defaults for the RAM access sequencer.
package ram_access_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 8;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ACCEPT,
        S_WR_SETUP,
        S_WR_STROBE,
        S_RD_SETUP,
        S_RD_WAIT,
        S_RD_HOLD,
        S_DONE
    } state_e;

endpackage

// File: rtl/ram_access_master_ctr.sv
// Burst address/beat counter: loads a start point, steps with address wrap.
module ram_burst_ctr
    import ram_access_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  start_len,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              last
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  beats_q, beats_d;

    always_comb begin
        addr_d  = addr_q;
        beats_d = beats_q;
        if (load) begin
            addr_d  = start_addr;
            beats_d = (start_len == '0) ? LEN_W'(1) : start_len;
        end else if (step) begin
            addr_d  = addr_q + ADDR_W'(1);
            beats_d = beats_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q  <= '0;
            beats_q <= '0;
        end else begin
            addr_q  <= addr_d;
            beats_q <= beats_d;
        end
    end

    assign cur_addr = addr_q;
    assign last     = (beats_q == LEN_W'(1));

endmodule

// File: rtl/ram_access_master.sv
// Initiator-side sequencer driving the single-port RAM strobes for
// single and burst reads/writes with valid/ready streaming.
module ram_access_master
    import ram_access_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int RD_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_input,
    input  logic [DATA_W-1:0] ram_data_output
);

    localparam int WAIT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

    state_e state_q, state_d;

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              wr_ready_q, wr_ready_d;
    logic              rd_valid_q, rd_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ram_rw_q, ram_rw_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [DATA_W-1:0] ram_data_input_q, ram_data_input_d;

    logic              ctr_load;
    logic              ctr_step;
    logic [ADDR_W-1:0] cur_addr;
    logic              last;

    ram_burst_ctr #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ctr_load),
        .step       (ctr_step),
        .start_addr (cmd_addr),
        .start_len  (cmd_len),
        .cur_addr   (cur_addr),
        .last       (last)
    );

    always_comb begin
        state_d          = state_q;
        wait_d           = wait_q;
        rd_data_d        = rd_data_q;
        ram_address_d    = ram_address_q;
        ram_data_input_d = ram_data_input_q;
        ctr_load         = 1'b0;
        ctr_step         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    ctr_load = 1'b1;
                    state_d  = cmd_we ? S_WR_ACCEPT : S_RD_SETUP;
                end
            end
            S_WR_ACCEPT: begin
                if (wr_valid && wr_ready_q) begin
                    ram_address_d    = cur_addr;
                    ram_data_input_d = wr_data;
                    state_d          = S_WR_SETUP;
                end
            end
            S_WR_SETUP: state_d = S_WR_STROBE;
            S_WR_STROBE: begin
                ctr_step = 1'b1;
                state_d  = last ? S_DONE : S_WR_ACCEPT;
            end
            S_RD_SETUP: begin
                ram_address_d = cur_addr;
                wait_d        = WAIT_W'(RD_WAIT - 1);
                state_d       = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (wait_q == '0) begin
                    rd_data_d = ram_data_output;
                    state_d   = S_RD_HOLD;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            S_RD_HOLD: begin
                if (rd_ready) begin
                    ctr_step = 1'b1;
                    state_d  = last ? S_DONE : S_RD_SETUP;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Outputs are decoded from the next state so they line up with it.
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        wr_ready_d  = (state_d == S_WR_ACCEPT);
        rd_valid_d  = (state_d == S_RD_HOLD);
        done_d      = (state_d == S_DONE);
        ram_rw_d    = (state_d == S_WR_STROBE) ? RW_WRITE : RW_READ;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            wait_q           <= '0;
            cmd_ready_q      <= 1'b0;
            wr_ready_q       <= 1'b0;
            rd_valid_q       <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            ram_rw_q         <= RW_READ;
            rd_data_q        <= '0;
            ram_address_q    <= '0;
            ram_data_input_q <= '0;
        end else begin
            state_q          <= state_d;
            wait_q           <= wait_d;
            cmd_ready_q      <= cmd_ready_d;
            wr_ready_q       <= wr_ready_d;
            rd_valid_q       <= rd_valid_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            ram_rw_q         <= ram_rw_d;
            rd_data_q        <= rd_data_d;
            ram_address_q    <= ram_address_d;
            ram_data_input_q <= ram_data_input_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign wr_ready       = wr_ready_q;
    assign rd_valid       = rd_valid_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign ram_rw         = ram_rw_q;
    assign rd_data        = rd_data_q;
    assign ram_address    = ram_address_q;
    assign ram_data_input = ram_data_input_q;

endmodule

// File: tb/tb_ram_access_master.sv
// Directed bench for ram_access_master with a behavioural 64K x 32 RAM.
module tb_ram_access_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b1;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic        ram_rw;
    logic [15:0] ram_address;
    logic [31:0] ram_data_input;
    logic [31:0] ram_data_output;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:65535];
    int          strobe_cnt = 0;
    int          done_cnt = 0;
    int          viol = 0;
    logic [15:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [15:0] prev_addr = '0;
    logic [31:0] prev_din = '0;
    logic [31:0] rdq [$];

    always #5 clk = ~clk;

    ram_access_master dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_we          (cmd_we),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_data         (wr_data),
        .rd_valid        (rd_valid),
        .rd_ready        (rd_ready),
        .rd_data         (rd_data),
        .busy            (busy),
        .done            (done),
        .ram_rw          (ram_rw),
        .ram_address     (ram_address),
        .ram_data_input  (ram_data_input),
        .ram_data_output (ram_data_output)
    );

    assign ram_data_output = mem[ram_address];

    always @(posedge clk) begin
        if (ram_rw) begin
            mem[ram_address] <= ram_data_input;
            strobe_cnt++;
            st_addr = ram_address;
            st_data = ram_data_input;
            if (ram_address !== prev_addr || ram_data_input !== prev_din)
                viol++;
        end
        prev_addr = ram_address;
        prev_din  = ram_data_input;
        if (done) done_cnt++;
        if (rd_valid && rd_ready) rdq.push_back(rd_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic we, input logic [15:0] a,
                            input logic [7:0] l, output bit ok);
        ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_len   = l;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic push_wr(input logic [31:0] d, output bit ok);
        ok = 1'b0;
        wr_valid = 1'b1;
        wr_data  = d;
        for (int i = 0; i < 50; i++) begin
            if (wr_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({cmd_ready, wr_ready, rd_valid, busy, done, ram_rw} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {cmd_ready, wr_ready, rd_valid, busy, done, ram_rw});
        end
        checks++;
        if ({rd_data, ram_address, ram_data_input} !== 80'h0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h/%h want 0",
                     rd_data, ram_address, ram_data_input);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_single_write();
        bit ok1, ok2, ok3;
        strobe_cnt = 0;
        done_cnt   = 0;
        send_cmd(1'b1, 16'h0003, 8'd1, ok1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy: got %b want 1", busy);
        end
        push_wr(32'hAAAAAAA3, ok2);
        wait_done(ok3);
        checks++;
        if ({ok1, ok2, ok3} !== 3'b111) begin
            errors++;
            $display("FAIL single_timeout: got %b want 111", {ok1, ok2, ok3});
        end
        checks++;
        if (strobe_cnt !== 1 || st_addr !== 16'h0003 || st_data !== 32'hAAAAAAA3) begin
            errors++;
            $display("FAIL single_strobe: got n=%0d a=%h d=%h want n=1 a=0003 d=aaaaaaa3",
                     strobe_cnt, st_addr, st_data);
        end
        checks++;
        if (mem[3] !== 32'hAAAAAAA3 || done_cnt !== 1) begin
            errors++;
            $display("FAIL single_mem: got %h done=%0d want aaaaaaa3 done=1",
                     mem[3], done_cnt);
        end
    endtask

    task automatic test_burst();
        bit ok1, ok2, ok3;
        bit okw;
        int bad;
        strobe_cnt = 0;
        okw = 1'b1;
        send_cmd(1'b1, 16'h0000, 8'd8, ok1);
        for (int i = 0; i < 8; i++) begin
            push_wr(32'hAAAAAAA0 + 32'(i), ok2);
            okw &= ok2;
        end
        wait_done(ok3);
        checks++;
        if (!(ok1 && okw && ok3) || strobe_cnt !== 8) begin
            errors++;
            $display("FAIL burst_write: got strobes=%0d ok=%b want 8 ok=1",
                     strobe_cnt, ok1 && okw && ok3);
        end
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (mem[i] !== 32'hAAAAAAA0 + 32'(i)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL burst_mem: got %0d bad words want 0", bad);
        end
        strobe_cnt = 0;
        rdq.delete();
        rd_ready = 1'b1;
        send_cmd(1'b0, 16'h0000, 8'd8, ok1);
        wait_done(ok3);
        checks++;
        if (rdq.size() !== 8 || !(ok1 && ok3)) begin
            errors++;
            $display("FAIL burst_read_count: got %0d want 8", rdq.size());
        end
        bad = 0;
        for (int i = 0; i < rdq.size(); i++)
            if (rdq[i] !== 32'hAAAAAAA0 + 32'(i)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL burst_read_data: got %0d bad beats want 0", bad);
        end
        checks++;
        if (strobe_cnt !== 0) begin
            errors++;
            $display("FAIL burst_read_rw: got %0d strobes want 0", strobe_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit ok1, ok2, ok3;
        int unstable;
        rdq.delete();
        rd_ready = 1'b0;
        send_cmd(1'b0, 16'h0005, 8'd2, ok1);
        ok2 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rd_valid) begin
                ok2 = 1'b1;
                break;
            end
            tick();
        end
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            if (rd_valid !== 1'b1 || rd_data !== 32'hAAAAAAA5) unstable++;
            tick();
        end
        checks++;
        if (!(ok1 && ok2) || unstable !== 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d unstable cycles ok=%b want 0 ok=1",
                     unstable, ok1 && ok2);
        end
        checks++;
        if (rdq.size() !== 0) begin
            errors++;
            $display("FAIL bp_no_beat: got %0d beats want 0", rdq.size());
        end
        rd_ready = 1'b1;
        wait_done(ok3);
        checks++;
        if (!ok3 || rdq.size() !== 2) begin
            errors++;
            $display("FAIL bp_count: got %0d want 2", rdq.size());
        end else begin
            checks++;
            if (rdq[0] !== 32'hAAAAAAA5 || rdq[1] !== 32'hAAAAAAA6) begin
                errors++;
                $display("FAIL bp_data: got %h %h want aaaaaaa5 aaaaaaa6",
                         rdq[0], rdq[1]);
            end
        end
    endtask

    task automatic test_wrap_len0();
        bit ok1, ok2, ok3, ok4;
        send_cmd(1'b1, 16'hFFFF, 8'd2, ok1);
        push_wr(32'h11111111, ok2);
        push_wr(32'h22222222, ok3);
        wait_done(ok4);
        checks++;
        if (mem[16'hFFFF] !== 32'h11111111 || mem[0] !== 32'h22222222) begin
            errors++;
            $display("FAIL wrap_mem: got %h %h want 11111111 22222222",
                     mem[16'hFFFF], mem[0]);
        end
        strobe_cnt = 0;
        done_cnt   = 0;
        send_cmd(1'b1, 16'h0010, 8'd0, ok1);
        push_wr(32'h33333333, ok2);
        wait_done(ok3);
        checks++;
        if (strobe_cnt !== 1 || done_cnt !== 1 || mem[16'h0010] !== 32'h33333333) begin
            errors++;
            $display("FAIL len0_write: got strobes=%0d done=%0d mem=%h want 1 1 33333333",
                     strobe_cnt, done_cnt, mem[16'h0010]);
        end
        checks++;
        if (wr_ready !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL len0_idle: got wr_ready=%b cmd_ready=%b want 0 1",
                     wr_ready, cmd_ready);
        end
        rdq.delete();
        send_cmd(1'b0, 16'hFFFF, 8'd0, ok1);
        wait_done(ok2);
        checks++;
        if (rdq.size() !== 1 || rdq[0] !== 32'h11111111) begin
            errors++;
            $display("FAIL len0_read: got n=%0d d=%h want n=1 d=11111111",
                     rdq.size(), rdq.size() > 0 ? rdq[0] : 32'h0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok1, ok2, ok3, ok4;
        send_cmd(1'b1, 16'h0020, 8'd4, ok1);
        push_wr(32'h44440000, ok2);
        push_wr(32'h44440001, ok3);
        ok4 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (ram_rw) begin
                ok4 = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!(ok1 && ok2 && ok3 && ok4)) begin
            errors++;
            $display("FAIL mid_reach_strobe: got %b want 1111", {ok1, ok2, ok3, ok4});
        end
        done_cnt = 0;
        rst_n = 1'b0;
        tick();
        checks++;
        if (ram_rw !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outs: got rw=%b busy=%b done=%b want 0 0 0",
                     ram_rw, busy, done);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || done_cnt !== 0) begin
            errors++;
            $display("FAIL mid_release: got cmd_ready=%b done=%0d want 1 0",
                     cmd_ready, done_cnt);
        end
        strobe_cnt = 0;
        send_cmd(1'b1, 16'h0030, 8'd1, ok1);
        push_wr(32'h55555555, ok2);
        wait_done(ok3);
        checks++;
        if (mem[16'h0030] !== 32'h55555555 || strobe_cnt !== 1 || done_cnt !== 1) begin
            errors++;
            $display("FAIL mid_recover: got mem=%h strobes=%0d done=%0d want 55555555 1 1",
                     mem[16'h0030], strobe_cnt, done_cnt);
        end
    endtask

    task automatic test_wr_stall();
        bit ok1, ok2, ok3, ok4;
        logic [15:0] a0;
        int moved;
        strobe_cnt = 0;
        send_cmd(1'b1, 16'h0040, 8'd1, ok1);
        ok2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (wr_ready) begin
                ok2 = 1'b1;
                break;
            end
            tick();
        end
        a0 = ram_address;
        moved = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ram_rw !== 1'b0 || ram_address !== a0) moved++;
        end
        checks++;
        if (!(ok1 && ok2) || moved !== 0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: got moved=%0d wr_ready=%b want 0 1",
                     moved, wr_ready);
        end
        push_wr(32'h66666666, ok3);
        wait_done(ok4);
        checks++;
        if (mem[16'h0040] !== 32'h66666666 || strobe_cnt !== 1 || !(ok3 && ok4)) begin
            errors++;
            $display("FAIL stall_resume: got mem=%h strobes=%0d want 66666666 1",
                     mem[16'h0040], strobe_cnt);
        end
    endtask

    task automatic test_timing();
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL strobe_timing: got %0d unstable strobes want 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst();
        test_backpressure();
        test_wrap_len0();
        test_reset_mid();
        test_wr_stall();
        test_timing();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
